// File: rtl/series_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// series_ctrl_pkg
//   Shared types and constants for the iterative series controller.
//   state_t  : controller FSM states, IDLE through DONE.
//   MODE_ADD : add_sub_mode value that makes the datapath add.
//   MODE_SUB : add_sub_mode value that makes the datapath subtract.
// ---------------------------------------------------------------------------
package series_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        MUL   = 3'd3,
        ACC   = 3'd4,
        INC   = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic MODE_ADD = 1'b1;
    localparam logic MODE_SUB = 1'b0;

endpackage

// File: rtl/series_controller.sv
// ---------------------------------------------------------------------------
// series_controller
//   Moore FSM that sequences the iterative series datapath (counter, term and
//   accumulator registers, multiplier, add/sub unit, comparator, operand mux).
//   A run performs n_terms multiply-accumulate iterations and then pulses done.
//   The block holds no arithmetic of its own, only control.
//
//   Optional feature: define SERIES_ALT_SIGN_EN to alternate add/subtract on
//   successive accumulate steps (first iteration adds). Without it every
//   accumulate step adds.
//
// Ports
//   clk          in   clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset
//   start        in   begin a run; only looked at in IDLE
//   n_terms      in   iteration count, captured when start is accepted
//   gt           in   comparator result (n_lat > datapath counter)
//   n_lat        out  captured iteration count, comparator input A
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse at the end of a run
//   cnt_rst      out  clear the datapath counter
//   cnt_en       out  increment the datapath counter
//   term_load    out  load the term register from the operand mux
//   acc_load     out  load the accumulator register
//   mux_sel      out  0 = initial operands, 1 = datapath results
//   add_sub_mode out  1 = add, 0 = subtract; only meaningful in ACC
// ---------------------------------------------------------------------------
module series_controller
    import series_ctrl_pkg::*;
#(
    parameter int BIT_NUM = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIT_NUM-1:0] n_terms,
    input  logic               gt,
    output logic [BIT_NUM-1:0] n_lat,
    output logic               busy,
    output logic               done,
    output logic               cnt_rst,
    output logic               cnt_en,
    output logic               term_load,
    output logic               acc_load,
    output logic               mux_sel,
    output logic               add_sub_mode
);

    state_t state_q;
    state_t state_d;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_lat   <= '0;
        end else begin
            state_q <= state_d;
            // The count is captured only when a run is accepted, so changes
            // to n_terms during a run cannot disturb the loop bound.
            if (state_q == IDLE && start) begin
                n_lat <= n_terms;
            end
        end
    end

`ifdef SERIES_ALT_SIGN_EN
    // Sign of the next accumulate step: 0 = add, 1 = subtract.
    logic sign_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
        end else if (state_q == INIT) begin
            sign_q <= 1'b0;
        end else if (state_q == INC) begin
            sign_q <= ~sign_q;
        end
    end
`endif

    // Next-state logic. The loop is pre-tested in CHECK, so n_lat == 0 runs
    // zero iterations, and the exit at cnt == n_lat means the counter never
    // has to wrap even for the largest count.
    // NOTE: assigning a default before the case keeps this block purely
    // combinational; a path that leaves a variable unassigned infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = INIT;
            INIT:    state_d = CHECK;
            CHECK:   state_d = gt ? MUL : DONE;
            MUL:     state_d = ACC;
            ACC:     state_d = INC;
            INC:     state_d = CHECK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode depends on the state register only (Moore outputs).
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        cnt_rst      = 1'b0;
        cnt_en       = 1'b0;
        term_load    = 1'b0;
        acc_load     = 1'b0;
        mux_sel      = 1'b0;
        add_sub_mode = MODE_SUB;
        case (state_q)
            INIT: begin
                busy      = 1'b1;
                cnt_rst   = 1'b1;
                term_load = 1'b1;
                acc_load  = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            MUL: begin
                busy      = 1'b1;
                term_load = 1'b1;
                mux_sel   = 1'b1;
            end
            ACC: begin
                busy     = 1'b1;
                acc_load = 1'b1;
                mux_sel  = 1'b1;
`ifdef SERIES_ALT_SIGN_EN
                add_sub_mode = sign_q ? MODE_SUB : MODE_ADD;
`else
                add_sub_mode = MODE_ADD;
`endif
            end
            INC: begin
                busy   = 1'b1;
                cnt_en = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_series_controller.sv
// ---------------------------------------------------------------------------
// tb_series_controller
//   Self-checking bench for series_controller. A small datapath model (counter
//   plus comparator) answers gt. Expected outputs for each cycle of a run are
//   derived from the run timeline: INIT in cycle 1, then n four-cycle
//   CHECK/MUL/ACC/INC iterations, a final CHECK and DONE in cycle 3+4n.
//   Honours SERIES_ALT_SIGN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_series_controller;

    localparam int BIT_NUM = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [BIT_NUM-1:0] n_terms;
    logic               gt;
    logic [BIT_NUM-1:0] n_lat;
    logic               busy;
    logic               done;
    logic               cnt_rst;
    logic               cnt_en;
    logic               term_load;
    logic               acc_load;
    logic               mux_sel;
    logic               add_sub_mode;

    int checks   = 0;
    int failures = 0;

    logic acc_modes[$];

    series_controller #(.BIT_NUM(BIT_NUM)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .n_terms      (n_terms),
        .gt           (gt),
        .n_lat        (n_lat),
        .busy         (busy),
        .done         (done),
        .cnt_rst      (cnt_rst),
        .cnt_en       (cnt_en),
        .term_load    (term_load),
        .acc_load     (acc_load),
        .mux_sel      (mux_sel),
        .add_sub_mode (add_sub_mode)
    );

    always #5 clk = ~clk;

    // Datapath counter and comparator model.
    logic [BIT_NUM-1:0] cnt = '0;
    always @(posedge clk) begin
        if (cnt_rst)     cnt <= '0;
        else if (cnt_en) cnt <= cnt + 1'b1;
    end
    assign gt = (n_lat > cnt);

    wire [7:0] outs = {busy, done, cnt_rst, cnt_en, term_load, acc_load, mux_sel, add_sub_mode};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expected_mode(input int k);
`ifdef SERIES_ALT_SIGN_EN
        return (k % 2 == 0);
`else
        return 1'b1;
`endif
    endfunction

    // Bit order: busy done cnt_rst cnt_en term_load acc_load mux_sel mode.
    function automatic logic [7:0] expected_outs(input int c, input int n);
        int p;
        int k;
        logic [7:0] v;
        v = 8'b1000_0000;
        if (c == 1) begin
            v = 8'b1010_1100;
        end else if (c == 3 + 4 * n) begin
            v = 8'b1100_0000;
        end else begin
            p = (c - 2) % 4;
            k = (c - 2) / 4;
            case (p)
                1:       v = 8'b1000_1010;
                2:       v = 8'b1000_0110 | {7'b0, expected_mode(k)};
                3:       v = 8'b1001_0000;
                default: v = 8'b1000_0000;
            endcase
        end
        return v;
    endfunction

    // Precondition: called at a falling edge while the DUT sits in IDLE.
    // With disturb set, start and n_terms are randomised throughout the run
    // and start is forced high in the DONE cycle; all of that must be ignored.
    task automatic run(input int n, input bit disturb);
        int last;
        int en_cnt;
        int acc_cnt;
        int done_cyc;
        logic [7:0] n8;
        last     = 3 + 4 * n;
        en_cnt   = 0;
        acc_cnt  = 0;
        done_cyc = -1;
        n8       = n[7:0];
        acc_modes.delete();
        start    = 1'b1;
        n_terms  = n8;
        @(posedge clk);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            check($sformatf("outs n=%0d cycle=%0d", n, c), {24'b0, outs}, {24'b0, expected_outs(c, n)});
            check($sformatf("n_lat n=%0d cycle=%0d", n, c), {24'b0, n_lat}, {24'b0, n8});
            if (cnt_en) en_cnt++;
            if (acc_load && c > 1) begin
                acc_cnt++;
                acc_modes.push_back(add_sub_mode);
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (disturb) begin
                start   = (c == last) ? 1'b1 : 1'($urandom_range(0, 1));
                n_terms = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("idle after run n=%0d", n), {24'b0, outs}, 32'd0);
        start = 1'b0;
        check($sformatf("cnt_en pulses n=%0d", n), en_cnt, n);
        check($sformatf("acc_load pulses n=%0d", n), acc_cnt, n);
        check($sformatf("done cycle n=%0d", n), done_cyc, last);
        check($sformatf("final count n=%0d", n), {24'b0, cnt}, {24'b0, n8});
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        n_terms = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outs", {24'b0, outs}, 32'd0);
        check("reset n_lat", {24'b0, n_lat}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle without start", {24'b0, outs}, 32'd0);

        // Zero iterations, then three iterations, both with disturbances.
        run(0, 1'b1);
        run(3, 1'b1);

        // Accumulate sign sequence over four iterations.
        run(4, 1'b0);
        check("acc mode count", acc_modes.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_modes.size())
                check($sformatf("acc mode iter %0d", i), {31'b0, acc_modes[i]}, {31'b0, expected_mode(i)});
        end

        // Reset while in ACC of a five-iteration run aborts without done.
        start   = 1'b1;
        n_terms = 8'd5;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("pre-abort outs cycle=%0d", c), {24'b0, outs}, {24'b0, expected_outs(c, 5)});
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort outs", {24'b0, outs}, 32'd0);
        check("abort n_lat", {24'b0, n_lat}, 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post-abort quiet %0d", c), {30'b0, busy, done}, 32'd0);
        end

        // Random lengths with random interference.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 12);
            run(n, 1'b1);
        end

        // Maximum count, then a back-to-back start in the first IDLE cycle.
        run(255, 1'b1);
        n = $urandom_range(1, 6);
        run(n, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
